rv_lockstep_checker: RTL and testbench

RV_LOCKSTEP_CHECKER -- requirements
Module: rv_lockstep_checker

---
 rtl/rv_lockstep_checker.sv | 189 ++++++++++++++++++
 tb/tb_rv_lockstep_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lockstep_checker.sv
// Lockstep retirement checker: replays each retired RV32 subset instruction on a
// shadow register file and flags control-flow or writeback disagreements.
module rv_lockstep_checker #(
  parameter int              XLEN        = 32,
  parameter int              NREGS       = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter bit              STOP_ON_ERR = 1'b1,
  parameter int              CNT_W       = 8,
  localparam int             RW          = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chk_enable,
  input  logic              err_clr,
  input  logic              retire_valid,
  input  logic [31:0]       retire_instr,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [XLEN-1:0]   retire_next_pc,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              err,
  output logic [2:0]        err_kind,
  output logic [XLEN-1:0]   err_pc,
  output logic [CNT_W-1:0]  err_count,
  output logic [31:0]       retired_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ILLEGAL = 3'd1;
  localparam logic [2:0] E_PC_SEQ  = 3'd2;
  localparam logic [2:0] E_WB_CTRL = 3'd3;
  localparam logic [2:0] E_WB_DATA = 3'd4;
  localparam logic [2:0] E_NEXT_PC = 3'd5;

  state_e            state_q;
  logic              err_q;
  logic [2:0]        err_kind_q;
  logic [XLEN-1:0]   err_pc_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [31:0]       retired_q;
  logic [XLEN-1:0]   exp_pc_q;
  logic [XLEN-1:0]   shadow_q [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RW-1:0]   rd_idx;
  logic [RW-1:0]   rs1_idx;
  logic [RW-1:0]   rs2_idx;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] pc_plus4;

  assign opcode  = retire_instr[6:0];
  assign funct3  = retire_instr[14:12];
  assign funct7  = retire_instr[31:25];
  assign rd_idx  = RW'(retire_instr[11:7]);
  assign rs1_idx = RW'(retire_instr[19:15]);
  assign rs2_idx = RW'(retire_instr[24:20]);

  assign imm_i = {{(XLEN-12){retire_instr[31]}}, retire_instr[31:20]};
  assign imm_b = {{(XLEN-13){retire_instr[31]}}, retire_instr[31], retire_instr[7],
                  retire_instr[30:25], retire_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){retire_instr[31]}}, retire_instr[31], retire_instr[19:12],
                  retire_instr[20], retire_instr[30:21], 1'b0};

  assign rs1_val  = (rs1_idx == '0) ? '0 : shadow_q[rs1_idx];
  assign rs2_val  = (rs2_idx == '0) ? '0 : shadow_q[rs2_idx];
  assign pc_plus4 = retire_pc + XLEN'(4);

  logic is_add, is_sub, is_addi, is_beq, is_bne, is_jal, is_illegal;

  assign is_add     = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub     = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi    = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_beq     = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne     = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_jal     = (opcode == 7'b1101111);
  assign is_illegal = !(is_add || is_sub || is_addi || is_beq || is_bne || is_jal);

  logic [XLEN-1:0] exp_val;
  logic [XLEN-1:0] exp_next;
  logic            exp_wr;
  logic            obs_wr;
  logic [2:0]      err_code;

  always_comb begin
    exp_val  = '0;
    exp_next = pc_plus4;
    if (is_add)  exp_val = rs1_val + rs2_val;
    if (is_sub)  exp_val = rs1_val - rs2_val;
    if (is_addi) exp_val = rs1_val + imm_i;
    if (is_jal) begin
      exp_val  = pc_plus4;
      exp_next = retire_pc + imm_j;
    end
    if ((is_beq && (rs1_val == rs2_val)) || (is_bne && (rs1_val != rs2_val)))
      exp_next = retire_pc + imm_b;
  end

  assign exp_wr = (is_add || is_sub || is_addi || is_jal) && (rd_idx != '0);
  assign obs_wr = wb_en && (wb_rd != '0);

  // Lowest-numbered failing check wins when several fire together.
  always_comb begin
    err_code = E_NONE;
    if (is_illegal)
      err_code = E_ILLEGAL;
    else if (retire_pc != exp_pc_q)
      err_code = E_PC_SEQ;
    else if ((exp_wr != obs_wr) || (exp_wr && obs_wr && (wb_rd != rd_idx)))
      err_code = E_WB_CTRL;
    else if (exp_wr && (wb_data != exp_val))
      err_code = E_WB_DATA;
    else if (retire_next_pc != exp_next)
      err_code = E_NEXT_PC;
  end

  logic checked;
  logic new_err;

  assign checked = (state_q == ST_RUN) && retire_valid;
  assign new_err = checked && (err_code != E_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      err_kind_q  <= '0;
      err_pc_q    <= '0;
      err_count_q <= '0;
      retired_q   <= '0;
      exp_pc_q    <= RESET_PC;
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
    end else begin
      if (checked) begin
        retired_q <= retired_q + 32'd1;
        // Shadow follows the reference result, so a bad DUT value never propagates.
        if (is_illegal) begin
          exp_pc_q <= retire_next_pc;
        end else begin
          exp_pc_q <= exp_next;
          if (exp_wr) shadow_q[rd_idx] <= exp_val;
        end
        if (new_err && (err_count_q != {CNT_W{1'b1}}))
          err_count_q <= err_count_q + CNT_W'(1);
      end

      if (new_err && (!err_q || err_clr)) begin
        err_q      <= 1'b1;
        err_kind_q <= err_code;
        err_pc_q   <= retire_pc;
      end else if (err_clr) begin
        err_q      <= 1'b0;
        err_kind_q <= '0;
        err_pc_q   <= '0;
      end

      unique case (state_q)
        ST_IDLE: if (chk_enable) state_q <= ST_RUN;
        ST_RUN: begin
          if (new_err && STOP_ON_ERR) state_q <= ST_HALT;
          else if (!chk_enable)       state_q <= ST_IDLE;
        end
        ST_HALT: if (err_clr) state_q <= chk_enable ? ST_RUN : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign err           = err_q;
  assign err_kind      = err_kind_q;
  assign err_pc        = err_pc_q;
  assign err_count     = err_count_q;
  assign retired_count = retired_q;
  assign state         = state_q;

endmodule

// File: tb/tb_rv_lockstep_checker.sv
// Bench for rv_lockstep_checker: a halting and a continuing instance share stimulus
// and are compared every cycle against an instruction-level reference model.
module tb_rv_lockstep_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        chk_enable;
  logic        err_clr;
  logic        retire_valid;
  logic [31:0] retire_instr;
  logic [31:0] retire_pc;
  logic [31:0] retire_next_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        a_err,   b_err;
  logic [2:0]  a_kind,  b_kind;
  logic [31:0] a_epc,   b_epc;
  logic [7:0]  a_ecnt,  b_ecnt;
  logic [31:0] a_rcnt,  b_rcnt;
  logic [1:0]  a_state, b_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_lockstep_checker #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0), .STOP_ON_ERR(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .chk_enable(chk_enable), .err_clr(err_clr),
    .retire_valid(retire_valid), .retire_instr(retire_instr), .retire_pc(retire_pc),
    .retire_next_pc(retire_next_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(a_err), .err_kind(a_kind), .err_pc(a_epc), .err_count(a_ecnt),
    .retired_count(a_rcnt), .state(a_state));

  rv_lockstep_checker #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0), .STOP_ON_ERR(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .chk_enable(chk_enable), .err_clr(err_clr),
    .retire_valid(retire_valid), .retire_instr(retire_instr), .retire_pc(retire_pc),
    .retire_next_pc(retire_next_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(b_err), .err_kind(b_kind), .err_pc(b_epc), .err_count(b_ecnt),
    .retired_count(b_rcnt), .state(b_state));

  // Reference model, index 0 = halting instance, 1 = continuing instance.
  logic [1:0]  m_state [2];
  logic        m_err   [2];
  logic [2:0]  m_kind  [2];
  logic [31:0] m_epc   [2];
  logic [7:0]  m_ecnt  [2];
  logic [31:0] m_rcnt  [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_regs  [2][32];

  task automatic model_update();
    string       mn;
    int          code, imm;
    logic [31:0] a, b, val, nxt;
    logic [4:0]  rd, rs1, rs2;
    bit          wr, obs_wr;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_state[m] = 0; m_err[m] = 0; m_kind[m] = 0; m_epc[m] = 0;
        m_ecnt[m] = 0; m_rcnt[m] = 0; m_pc[m] = 0;
        for (int r = 0; r < 32; r++) m_regs[m][r] = 0;
        continue;
      end
      code = 0;
      if (m_state[m] == 1 && retire_valid) begin
        rd = retire_instr[11:7]; rs1 = retire_instr[19:15]; rs2 = retire_instr[24:20];
        mn = "ILLEGAL";
        if (retire_instr[6:0] == 7'h33 && retire_instr[14:12] == 0 && retire_instr[31:25] == 7'h00) mn = "ADD";
        if (retire_instr[6:0] == 7'h33 && retire_instr[14:12] == 0 && retire_instr[31:25] == 7'h20) mn = "SUB";
        if (retire_instr[6:0] == 7'h13 && retire_instr[14:12] == 0) mn = "ADDI";
        if (retire_instr[6:0] == 7'h63 && retire_instr[14:12] == 0) mn = "BEQ";
        if (retire_instr[6:0] == 7'h63 && retire_instr[14:12] == 1) mn = "BNE";
        if (retire_instr[6:0] == 7'h6f) mn = "JAL";
        a = m_regs[m][rs1]; b = m_regs[m][rs2];
        val = 0; nxt = retire_pc + 4;
        if (mn == "ADD") val = a + b;
        if (mn == "SUB") val = a - b;
        if (mn == "ADDI") begin
          imm = int'(retire_instr[31:20]); if (imm >= 2048) imm -= 4096;
          val = a + 32'(imm);
        end
        if (mn == "BEQ" || mn == "BNE") begin
          imm = int'({retire_instr[31], retire_instr[7], retire_instr[30:25], retire_instr[11:8], 1'b0});
          if (imm >= 4096) imm -= 8192;
          if ((mn == "BEQ") == (a == b)) nxt = retire_pc + 32'(imm);
        end
        if (mn == "JAL") begin
          imm = int'({retire_instr[31], retire_instr[19:12], retire_instr[20], retire_instr[30:21], 1'b0});
          if (imm >= (1 << 20)) imm -= (1 << 21);
          val = retire_pc + 4; nxt = retire_pc + 32'(imm);
        end
        wr = (mn == "ADD" || mn == "SUB" || mn == "ADDI" || mn == "JAL") && rd != 0;
        obs_wr = wb_en && wb_rd != 0;
        if (mn == "ILLEGAL") code = 1;
        else if (retire_pc != m_pc[m]) code = 2;
        else if (wr != obs_wr || (wr && wb_rd != rd)) code = 3;
        else if (wr && wb_data != val) code = 4;
        else if (retire_next_pc != nxt) code = 5;
        if (mn == "ILLEGAL") m_pc[m] = retire_next_pc;
        else begin
          m_pc[m] = nxt;
          if (wr) m_regs[m][rd] = val;
        end
        m_rcnt[m] = m_rcnt[m] + 1;
        if (code != 0 && m_ecnt[m] != 8'hFF) m_ecnt[m] = m_ecnt[m] + 1;
      end
      if (code != 0 && (!m_err[m] || err_clr)) begin
        m_err[m] = 1; m_kind[m] = 3'(code); m_epc[m] = retire_pc;
      end else if (err_clr) begin
        m_err[m] = 0; m_kind[m] = 0; m_epc[m] = 0;
      end
      case (m_state[m])
        2'd0: if (chk_enable) m_state[m] = 1;
        2'd1: if (code != 0 && m == 0) m_state[m] = 2; else if (!chk_enable) m_state[m] = 0;
        default: if (err_clr) m_state[m] = chk_enable ? 2'd1 : 2'd0;
      endcase
    end
  endtask

  function automatic logic [77:0] dut_vec(int m);
    if (m == 0) return {a_state, a_err, a_kind, a_epc, a_ecnt, a_rcnt};
    return {b_state, b_err, b_kind, b_epc, b_ecnt, b_rcnt};
  endfunction

  function automatic logic [77:0] mdl_vec(int m);
    return {m_state[m], m_err[m], m_kind[m], m_epc[m], m_ecnt[m], m_rcnt[m]};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    logic [4:0] d, s1, s2;
    d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
    return {f7, s2, s1, 3'b000, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i; logic [4:0] d, s1;
    i = 12'(imm); d = 5'(rd); s1 = 5'(rs1);
    return {i, s1, 3'b000, d, 7'h13};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [12:0] i; logic [4:0] s1, s2;
    i = 13'(imm); s1 = 5'(rs1); s2 = 5'(rs2);
    return {i[12], i[10:5], s2, s1, f3, i[4:1], i[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_jal(input int rd, input int imm);
    logic [20:0] i; logic [4:0] d;
    i = 21'(imm); d = 5'(rd);
    return {i[20], i[10:1], i[11], i[19:12], d, 7'h6f};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    if (retire_valid)
      $display("t=%0t rst=%0d en=%0d clr=%0d pc=%h instr=%h nxt=%h wb=%0d/x%0d/%h | a st=%0d err=%0d kind=%0d cnt=%0d | b st=%0d err=%0d kind=%0d cnt=%0d",
               $time, rst, chk_enable, err_clr, retire_pc, retire_instr, retire_next_pc, wb_en, wb_rd, wb_data,
               a_state, a_err, a_kind, a_ecnt, b_state, b_err, b_kind, b_ecnt);
  endtask

  task automatic quiet();
    rst = 0; err_clr = 0; retire_valid = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    retire_instr = 0; retire_pc = 0; retire_next_pc = 0;
  endtask

  task automatic retire(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] nxt,
                        input logic wen, input int wrd, input logic [31:0] wdata);
    retire_valid = 1; retire_instr = instr; retire_pc = pc; retire_next_pc = nxt;
    wb_en = wen; wb_rd = 5'(wrd); wb_data = wdata;
  endtask

  task automatic restart();
    quiet(); rst = 1; chk_enable = 0; cycle();
    rst = 0; chk_enable = 1; cycle();
  endtask

  task automatic test_reset();
    quiet(); rst = 1; chk_enable = 0;
    cycle(); cycle();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== 78'h0) begin
        failures++; $display("FAIL reset_state dut%0d got=%h exp=0", m, dut_vec(m));
      end
    end
  endtask

  task automatic test_basic();
    restart();
    checks++;
    if (a_state !== 2'd1) begin failures++; $display("FAIL enable_run got=%0d exp=1", a_state); end
    retire(enc_addi(1, 0, 5), 32'd0, 32'd4, 1, 1, 32'd5); cycle();
    checks++;
    if ({a_err, a_rcnt} !== {1'b0, 32'd1}) begin
      failures++; $display("FAIL addi_clean got err=%0d rcnt=%0d exp err=0 rcnt=1", a_err, a_rcnt);
    end
    retire(enc_r(7'h00, 2, 1, 1), 32'd4, 32'd8, 1, 2, 32'd9); cycle();
    checks++;
    if ({a_err, a_kind, a_epc, a_state, a_ecnt} !== {1'b1, 3'd4, 32'd4, 2'd2, 8'd1}) begin
      failures++; $display("FAIL add_wbdata got err=%0d kind=%0d pc=%h st=%0d cnt=%0d exp 1/4/4/2/1",
                           a_err, a_kind, a_epc, a_state, a_ecnt);
    end
    quiet(); cycle();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== mdl_vec(m)) begin
        failures++; $display("FAIL basic_model dut%0d got=%h exp=%h", m, dut_vec(m), mdl_vec(m));
      end
    end
  endtask

  task automatic test_branch_jal();
    restart();
    retire(enc_addi(1, 0, 5), 32'd0, 32'd4, 1, 1, 32'd5); cycle();
    retire(enc_addi(2, 0, 1), 32'd4, 32'd8, 1, 2, 32'd1); cycle();
    retire(enc_b(3'b000, 1, 1, 8), 32'd8, 32'd12, 0, 0, 32'd0); cycle();
    checks++;
    if ({b_kind, b_state, a_state} !== {3'd5, 2'd1, 2'd2}) begin
      failures++; $display("FAIL beq_nextpc got bkind=%0d bst=%0d ast=%0d exp 5/1/2", b_kind, b_state, a_state);
    end
    retire(enc_addi(3, 0, 7), 32'd16, 32'd20, 1, 3, 32'd7); cycle();
    checks++;
    if ({b_ecnt, b_rcnt} !== {8'd1, 32'd4}) begin
      failures++; $display("FAIL after_branch_pc got cnt=%0d rcnt=%0d exp 1/4", b_ecnt, b_rcnt);
    end
    retire(enc_jal(0, 16), 32'd20, 32'd36, 1, 0, $urandom); cycle();
    retire(enc_addi(4, 0, 2), 32'd36, 32'd40, 1, 4, 32'd2); cycle();
    checks++;
    if ({b_ecnt, b_kind, b_rcnt} !== {8'd1, 3'd5, 32'd6}) begin
      failures++; $display("FAIL jal_x0 got cnt=%0d kind=%0d rcnt=%0d exp 1/5/6", b_ecnt, b_kind, b_rcnt);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== mdl_vec(m)) begin
        failures++; $display("FAIL branch_model dut%0d got=%h exp=%h", m, dut_vec(m), mdl_vec(m));
      end
    end
  endtask

  task automatic test_illegal_clear();
    restart();
    retire(32'h0000_0073, 32'd0, 32'd4, 0, 0, 32'd0); cycle();
    checks++;
    if ({a_err, a_kind, a_state, a_ecnt} !== {1'b1, 3'd1, 2'd2, 8'd1}) begin
      failures++; $display("FAIL illegal got err=%0d kind=%0d st=%0d cnt=%0d exp 1/1/2/1", a_err, a_kind, a_state, a_ecnt);
    end
    quiet(); err_clr = 1; cycle();
    checks++;
    if ({a_err, a_state, a_ecnt} !== {1'b0, 2'd1, 8'd1}) begin
      failures++; $display("FAIL err_clr got err=%0d st=%0d cnt=%0d exp 0/1/1", a_err, a_state, a_ecnt);
    end
    retire(32'h0000_0073, 32'd4, 32'd8, 0, 0, 32'd0); cycle();
    // New PC_SEQ error arriving together with err_clr on the continuing instance.
    retire(enc_addi(1, 0, 1), 32'd100, 32'd104, 1, 1, 32'd1); err_clr = 1; cycle();
    checks++;
    if ({b_err, b_kind, b_epc, b_ecnt} !== {1'b1, 3'd2, 32'd100, 8'd3}) begin
      failures++; $display("FAIL clr_coincide got err=%0d kind=%0d pc=%h cnt=%0d exp 1/2/64/3", b_err, b_kind, b_epc, b_ecnt);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== mdl_vec(m)) begin
        failures++; $display("FAIL clear_model dut%0d got=%h exp=%h", m, dut_vec(m), mdl_vec(m));
      end
    end
  endtask

  task automatic test_saturate();
    restart();
    for (int i = 0; i < 260; i++) begin
      retire(32'hFFFF_FFFF, 32'(i * 4), 32'(i * 4 + 4), 0, 0, 32'd0);
      cycle();
    end
    checks++;
    if ({b_ecnt, b_rcnt} !== {8'd255, 32'd260}) begin
      failures++; $display("FAIL saturate got cnt=%0d rcnt=%0d exp 255/260", b_ecnt, b_rcnt);
    end
    rst = 1; cycle();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== 78'h0) begin
        failures++; $display("FAIL midrun_reset dut%0d got=%h exp=0", m, dut_vec(m));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] iss_regs [32];
    logic [31:0] iss_pc, a, b, val, nxt, instr;
    int kind, rd, rs1, rs2, imm, fault;
    bit wr;
    restart();
    iss_pc = 0;
    for (int r = 0; r < 32; r++) iss_regs[r] = 0;
    for (int n = 0; n < 500; n++) begin
      quiet();
      chk_enable = ($urandom_range(0, 19) != 0);
      err_clr    = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
      a = iss_regs[rs1]; b = iss_regs[rs2];
      val = 0; nxt = iss_pc + 4; wr = 0; instr = 0;
      case (kind)
        0, 1: begin instr = enc_r(7'h00, rd, rs1, rs2); val = a + b; wr = 1; end
        2:    begin instr = enc_r(7'h20, rd, rs1, rs2); val = a - b; wr = 1; end
        3, 4: begin imm = $urandom_range(0, 127) - 64; instr = enc_addi(rd, rs1, imm); val = a + 32'(imm); wr = 1; end
        5, 6: begin
          imm = $urandom_range(0, 16) * 4 - 32;
          instr = enc_b((kind == 5) ? 3'b000 : 3'b001, rs1, rs2, imm);
          if ((kind == 5) == (a == b)) nxt = iss_pc + 32'(imm);
        end
        7:    begin imm = $urandom_range(0, 16) * 4 - 32; instr = enc_jal(rd, imm); val = iss_pc + 4; nxt = iss_pc + 32'(imm); wr = 1; end
        default: instr = {$urandom} | 32'h7F;
      endcase
      wr = wr && rd != 0;
      if (kind != 9) begin
        retire(instr, iss_pc, nxt, wr, wr ? rd : 0, wr ? val : $urandom);
        fault = $urandom_range(0, 11);
        if (fault == 0) retire_pc = retire_pc + 4;
        if (fault == 1) wb_data = wb_data ^ 32'h1;
        if (fault == 2) begin wb_en = ~wb_en; wb_rd = 5'($urandom_range(1, 7)); end
        if (fault == 3) retire_next_pc = retire_next_pc + 4;
        if (fault == 4 && wr) wb_rd = wb_rd ^ 5'h8;
        if (wr) iss_regs[rd] = val;
        iss_pc = nxt;
      end
      cycle();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== mdl_vec(m)) begin
          failures++; $display("FAIL random_model n=%0d dut%0d got=%h exp=%h", n, m, dut_vec(m), mdl_vec(m));
        end
      end
    end
  endtask

  initial begin
    quiet(); chk_enable = 0; rst = 1;
    test_reset();
    test_basic();
    test_branch_jal();
    test_illegal_clear();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
